// File: rtl/lobovic_pkg.sv
// Shared definitions for the VRAM arbiter: default sizes,
// return-path source tag and arbiter FSM state.
package lobovic_pkg;

  localparam int ADDR_W_DFLT       = 14;
  localparam int DATA_W_DFLT       = 8;
  localparam int STARVE_LIMIT_DFLT = 255;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_HOST = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/lobovic_rd_pipe.sv
// Read return path: two-stage source tag follows each access so
// RAM read data is steered to exactly one registered consumer.
module lobovic_rd_pipe
  import lobovic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  src_t              tag_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  src_t              tag1_q, tag1_d;
  src_t              tag2_q, tag2_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    tag1_d        = tag_in;
    tag2_d        = tag1_q;
    vid_valid_d   = (tag2_q == SRC_VID);
    host_rvalid_d = (tag2_q == SRC_HOST);
    vid_data_d    = vid_valid_d ? ram_rdata : vid_data_q;
    host_rdata_d  = host_rvalid_d ? ram_rdata : host_rdata_q;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tag1_q        <= SRC_NONE;
      tag2_q        <= SRC_NONE;
      vid_valid_q   <= 1'b0;
      vid_data_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      vid_valid_q   <= vid_valid_d;
      vid_data_q    <= vid_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign vid_valid   = vid_valid_q;
  assign vid_data    = vid_data_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority,
// host waits with a saturating starvation counter.
module vram_arbiter
  import lobovic_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DFLT,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve
);

  localparam logic [7:0] LIM = STARVE_LIMIT[7:0];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              host_grant;
  src_t              tag_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (host_req) state_d = vid_req ? ST_WAIT : ST_ISSUE;
      ST_WAIT:
        if (!host_req)    state_d = ST_IDLE;
        else if (!vid_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ISSUE is only entered from IDLE/WAIT, so ack can never double up
  assign host_grant = (state_d == ST_ISSUE);

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT)
      cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 8'd1;
    starve_d    = starve_q | ((state_q == ST_WAIT) && (cnt_d == LIM));
    ram_en_d    = vid_req | host_grant;
    ram_we_d    = host_grant & host_we;
    host_ack_d  = host_grant;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_d       = SRC_NONE;
    if (vid_req) begin
      ram_addr_d = vid_addr;
      tag_d      = SRC_VID;
    end else if (host_grant) begin
      ram_addr_d = host_addr;
      if (host_we) ram_wdata_d = host_wdata;
      else         tag_d       = SRC_HOST;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      host_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      host_ack_q  <= host_ack_d;
    end
  end

  lobovic_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .tag_in     (tag_d),
    .ram_rdata  (ram_rdata),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata)
  );

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign host_ack  = host_ack_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand sequences
// for reset/starvation, then random traffic against a model.
module tb_vram_arbiter;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        host_req;
  logic        host_we;
  logic [13:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        starve;

  always #10 clk_50M = ~clk_50M;

  vram_arbiter #(
    .ADDR_W(14),
    .DATA_W(8),
    .STARVE_LIMIT(255)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .starve     (starve)
  );

  // single-port synchronous VRAM
  logic [7:0] ram [0:16383];
  always @(posedge clk_50M)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h123) return 8'h5A;
    if (a < 4)      return 8'(8'h10 + a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic drive(input logic vr, input logic [13:0] va,
                       input logic hr, input logic hw,
                       input logic [13:0] ha, input logic [7:0] hd);
    vid_req    = vr;
    vid_addr   = va;
    host_req   = hr;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ram_en, ram_we, ram_addr, ram_wdata, host_ack,
                vid_valid, vid_data, host_rvalid, host_rdata, starve});
  endfunction

  typedef struct {
    logic vr; logic [13:0] va;
    logic hr; logic hw; logic [13:0] ha; logic [7:0] hd;
    logic en; logic we; logic [13:0] ad;
    logic vv; logic [7:0] vd;
    logic ack; logic rv; logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(
    input logic vr, input logic [13:0] va, input logic hr,
    input logic hw, input logic [13:0] ha, input logic [7:0] hd,
    input logic en, input logic we, input logic [13:0] ad,
    input logic vv, input logic [7:0] vd, input logic ack,
    input logic rv, input logic [7:0] rd);
    vec_t v;
    v.vr = vr; v.va = va; v.hr = hr; v.hw = hw; v.ha = ha;
    v.hd = hd; v.en = en; v.we = we; v.ad = ad; v.vv = vv;
    v.vd = vd; v.ack = ack; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  vec_t tbl[$];

  // random-phase model state
  logic [7:0]  ref_mem [0:15];
  logic        pv [4];
  logic [7:0]  pvd [4];
  logic        pr [4];
  logic [7:0]  prd [4];
  logic        e_en, e_we, e_ack;
  logic [13:0] e_ad;
  logic [7:0]  e_wd;
  logic        h_busy, h_we;
  logic [13:0] h_a;
  logic [7:0]  h_d;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, got, first_j, cnt;
    logic vr;
    logic [13:0] va;
    for (int i = 0; i < 16384; i++) ram[i] = init_val(i);
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    // vid pulse 0x0123
    tbl.push_back(mk(1,14'h0123,0,0,0,0, 1,0,14'h0123, 0,0,    0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123, 0,0,    0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123, 1,8'h5A,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123, 0,0,    0,0,0));
    // four back-to-back video reads
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,14'(i),0,0,0,0, 1,0,14'(i),
                       i >= 2, (i >= 2) ? 8'(8'h0E + i) : 8'h00,
                       0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'd3, 1,8'h12,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'd3, 1,8'h13,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'd3, 0,0,    0,0,0));
    // host write then read of 0x3FFF
    tbl.push_back(mk(0,0,1,1,14'h3FFF,8'hA5, 1,1,14'h3FFF,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h3FFF,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,14'h3FFF,0, 1,0,14'h3FFF,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h3FFF,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h3FFF,0,0,0,1,8'hA5));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h3FFF,0,0,0,0,0));
    // host and video collide: video first, host when video idles
    tbl.push_back(mk(1,14'd1,1,0,14'h0123,0, 1,0,14'd1,0,0,0,0,0));
    tbl.push_back(mk(1,14'd2,1,0,14'h0123,0, 1,0,14'd2,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,14'h0123,0, 1,0,14'h0123,1,8'h11,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123,1,8'h12,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123,0,0,0,1,8'h5A));
    tbl.push_back(mk(0,0,0,0,0,0,        0,0,14'h0123,0,0,0,0,0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_50M);
    chk("reset_state", all_outs(), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].vr, tbl[i].va, tbl[i].hr, tbl[i].hw,
            tbl[i].ha, tbl[i].hd);
      @(negedge clk_50M);
      chk($sformatf("vec%0d", i),
          64'({ram_en, ram_we, ram_addr, host_ack, vid_valid,
               tbl[i].vv ? vid_data : 8'h00, host_rvalid,
               tbl[i].rv ? host_rdata : 8'h00,
               tbl[i].we ? ram_wdata : 8'h00}),
          64'({tbl[i].en, tbl[i].we, tbl[i].ad, tbl[i].ack,
               tbl[i].vv, tbl[i].vd, tbl[i].rv, tbl[i].rd,
               tbl[i].we ? tbl[i].hd : 8'h00}));
    end

    // reset right after a video request discards the read
    drive(1, 14'd2, 0, 0, 0, 0);
    @(negedge clk_50M);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_50M);
    chk("rst_all_zero", all_outs(), 64'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk_50M);
      cnt += int'(vid_valid) + int'(host_rvalid);
    end
    chk("rst_discard", 64'(cnt), 64'd0);

    // video hogs the RAM for 300 cycles while host waits
    drive(1, 14'd5, 1, 1, 14'h0200, 8'h77);
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50M);
      acks += int'(host_ack);
      if (i == 254) chk("starve_before_limit", 64'(starve), 64'd0);
      if (i == 255) chk("starve_at_limit", 64'(starve), 64'd1);
    end
    chk("no_ack_while_vid", 64'(acks), 64'd0);
    vid_req = 1'b0;
    got = 0;
    first_j = -1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_50M);
      if (host_ack) begin
        got++;
        if (first_j < 0) first_j = j;
        host_req = 1'b0;
      end
    end
    chk("starve_host_acks", 64'(got), 64'd1);
    chk("starve_ack_first_idle", 64'(first_j), 64'd0);
    chk("starve_sticky", 64'(starve), 64'd1);
    chk("starve_write_data", 64'(ram[14'h0200]), 64'h77);
    rst = 1'b1;
    @(negedge clk_50M);
    chk("starve_cleared", 64'(starve), 64'd0);
    rst = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 4; i++) begin
      pv[i] = 0; pvd[i] = 0; pr[i] = 0; prd[i] = 0;
    end
    e_en = 0; e_we = 0; e_ack = 0; e_ad = 0; e_wd = 0;
    h_busy = 0; h_we = 0; h_a = 0; h_d = 0;
    for (int k = 0; k < 500; k++) begin
      chk($sformatf("rand%0d", k),
          64'({ram_en, ram_we, ram_addr, host_ack, vid_valid,
               pv[k%4] ? vid_data : 8'h00, host_rvalid,
               pr[k%4] ? host_rdata : 8'h00,
               e_we ? ram_wdata : 8'h00, starve}),
          64'({e_en, e_we, e_ad, e_ack, pv[k%4], pvd[k%4],
               pr[k%4], prd[k%4], e_we ? e_wd : 8'h00, 1'b0}));
      pv[k%4] = 0; pvd[k%4] = 0; pr[k%4] = 0; prd[k%4] = 0;
      if (e_ack) h_busy = 0;
      else if (!h_busy && $urandom_range(0, 2) == 0) begin
        h_busy = 1;
        h_we   = 1'($urandom);
        h_a    = 14'($urandom_range(0, 15));
        h_d    = 8'($urandom);
      end
      vr = ($urandom_range(0, 4) < 2);
      va = 14'($urandom_range(0, 15));
      drive(vr, va, h_busy, h_we, h_a, h_d);
      e_en = 0; e_we = 0;
      if (vr) begin
        e_en = 1; e_ad = va; e_ack = 0;
        pv[(k+3)%4] = 1; pvd[(k+3)%4] = ref_mem[va[3:0]];
      end else if (h_busy && !e_ack) begin
        e_en = 1; e_ad = h_a; e_ack = 1;
        if (h_we) begin
          e_we = 1; e_wd = h_d; ref_mem[h_a[3:0]] = h_d;
        end else begin
          pr[(k+3)%4] = 1; prd[(k+3)%4] = ref_mem[h_a[3:0]];
        end
      end else begin
        e_ack = 0;
      end
      @(negedge clk_50M);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters, SHALL be provided exactly as follows:
- ADDR_W, 14: VRAM address width.
- DATA_W, 8: VRAM data width.
- STARVE_LIMIT, 255: host wait cycles before starve flag sets.

REQ-002 Ports, SHALL be provided exactly as follows:
- clk_50M  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vid_req  in  1  video fetch read request, single-cycle pulse.
- vid_addr  in  ADDR_W  video fetch address, valid with vid_req.
- vid_valid  out  1  video read data valid, one-cycle pulse.
- vid_data  out  DATA_W  video read data.
- host_req  in  1  host (UART bridge) request, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  ADDR_W  host address; stable while host_req is high.
- host_wdata  in  DATA_W  host write data; stable while host_req is high.
- host_ack  out  1  one-cycle pulse; host request issued to RAM.
- host_rvalid  out  1  host read data valid, one-cycle pulse.
- host_rdata  out  DATA_W  host read data.
- ram_en, ram_we  out  1  single-port synchronous VRAM enable and write strobe.
- ram_addr  out  ADDR_W  VRAM address.
- ram_wdata  out  DATA_W  VRAM write data.
- ram_rdata  in  DATA_W  VRAM read data, valid the cycle after ram_en with ram_we low.
- starve  out  1  sticky flag: host starvation limit reached.

Function
REQ-003 At most one RAM access SHALL issue per cycle; ram_en, ram_we, ram_addr, ram_wdata and host_ack SHALL all be registered.
REQ-004 Grant decision at edge t, RAM signals at t+1; video request SHALL take absolute priority over host request.
REQ-005 Video read latency SHALL be fixed: vid_valid high exactly 3 cycles after the edge sampling vid_req (issue t+1, ram_rdata t+2, registered output t+3).
REQ-006 vid_req may pulse on consecutive cycles; each SHALL yield one vid_valid in order with no bubbles.
REQ-007 Host is granted at an edge SHALL require: host_req high, vid_req low, and host_ack not currently high (no double issue).
REQ-008 host_ack SHALL be asserted in the same cycle as the corresponding ram_en.
REQ-009 Host write: ram_we = 1 with host_wdata; host_rvalid SHALL NOT pulse.
REQ-010 Host read: host_rvalid SHALL pulse 2 cycles after host_ack with the read data.
REQ-011 Return path SHALL carry a 2-stage source tag (NONE/VID/HOST) so read data is steered to exactly one consumer.
REQ-012 FSM states SHALL be:
- IDLE: no host grant pending.
- WAIT: host_req high and blocked by video; wait counter increments each cycle.
- ISSUE: host granted this cycle.
REQ-013 FSM transitions SHALL be:
- IDLE -> WAIT when host_req is high and vid_req is high.
- IDLE -> ISSUE when host_req is high and vid_req is low.
- WAIT -> ISSUE on the first cycle vid_req is low.
- ISSUE -> IDLE unconditionally.
REQ-014 Wait counter: 8-bit; SHALL clear on ISSUE and saturate at STARVE_LIMIT.
REQ-015 starve SHALL set when the counter reaches STARVE_LIMIT; it clears only on rst, and video priority is unchanged.
REQ-016 Host dropping host_req while in WAIT (protocol violation) SHALL return the FSM to IDLE with no access issued.
REQ-017 When no grant is made, ram_en SHALL be 0 and ram_we SHALL be 0; ram_addr and ram_wdata hold their last value.

Reset
REQ-018 On rst, the following SHALL be 0: ram_en, ram_we, ram_addr, ram_wdata, host_ack, vid_valid, host_rvalid, vid_data, host_rdata, starve, wait counter and tag pipeline; FSM SHALL go to IDLE.
REQ-019 rst asserted mid-operation SHALL discard in-flight reads: no vid_valid or host_rvalid in the cycles after rst deasserts unless newly requested.

Structure
REQ-020 Shared package lobovic_pkg SHALL hold ADDR_W, DATA_W and STARVE_LIMIT defaults, the source-tag enum (NONE/VID/HOST) and the FSM state enum.
REQ-021 One sub-module, lobovic_rd_pipe (tag shift register plus data return steering), SHALL be used; FSM and counter stay in vram_arbiter.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- vid_req pulse, addr 0x0123, RAM holds 0x5A -> ram_en at t+1, vid_valid with 0x5A at t+3.
- vid_req on 4 consecutive cycles, addrs 0..3 -> 4 consecutive vid_valid, data in order.
- host write addr 0x3FFF data 0xA5, then host read of same addr -> one host_ack each; host_rvalid 0xA5 two cycles after second ack.
- host_req and vid_req same cycle -> video issued first; host_ack on the first cycle vid_req is low; exactly one host access.
- vid_req held high for 300 cycles with host_req pending -> starve = 1 after 255 waits; stays 1 after host is served; clears on rst.
- rst for 1 cycle directly after a vid_req -> no vid_valid; all outputs 0 the cycle after rst.
